// File: rtl/alu_sweep_seq_if.sv
// Bus between the sweep sequencer, its host and the alu_4bit it drives.
// The master side issues sweep requests and returns ALU results; the slave side is the sequencer.
interface alu_sweep_seq_if;
  logic       start;
  logic       abort;
  logic [3:0] A_in;
  logic [3:0] B_in;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] ALU_Sel;
  logic [3:0] ALU_Out;
  logic       Carry_Out;
  logic       busy;
  logic       res_valid;
  logic [2:0] res_sel;
  logic [4:0] res_data;
  logic       done;
  logic [7:0] checksum;

  modport master (
    output start, abort, A_in, B_in, ALU_Out, Carry_Out,
    input  A, B, ALU_Sel, busy, res_valid, res_sel, res_data, done, checksum
  );

  modport slave (
    input  start, abort, A_in, B_in, ALU_Out, Carry_Out,
    output A, B, ALU_Sel, busy, res_valid, res_sel, res_data, done, checksum
  );
endinterface

// File: rtl/alu_sweep_seq.sv
// Sweeps an external 4-bit ALU through all eight opcodes for one operand pair,
// capturing each {carry, result} after DWELL cycles and accumulating a checksum.
module alu_sweep_seq #(
  parameter int unsigned DWELL = 4
) (
  input logic            clk,
  input logic            rst_n,
  alu_sweep_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  localparam logic [3:0] DwellLast = 4'(DWELL - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [2:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       valid_q, valid_d;
  logic [2:0] res_sel_q, res_sel_d;
  logic [4:0] res_data_q, res_data_d;
  logic       done_q, done_d;
  logic [7:0] checksum_q, checksum_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    res_sel_d  = res_sel_q;
    res_data_d = res_data_q;
    done_d     = 1'b0;
    checksum_d = checksum_q;

    unique case (state_q)
      StIdle: begin
        // abort outranks a simultaneous start
        if (bus.start && !bus.abort) begin
          a_d        = bus.A_in;
          b_d        = bus.B_in;
          sel_d      = 3'd0;
          cnt_d      = 4'd0;
          checksum_d = 8'd0;
          busy_d     = 1'b1;
          state_d    = StDrive;
        end
      end
      StDrive: begin
        if (bus.abort) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (cnt_q == DwellLast) begin
          res_data_d = {bus.Carry_Out, bus.ALU_Out};
          res_sel_d  = sel_q;
          valid_d    = 1'b1;
          checksum_d = checksum_q + {3'b000, res_data_d};
          cnt_d      = 4'd0;
          if (sel_q == 3'd7) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            sel_d = sel_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      sel_q      <= 3'd0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      res_sel_q  <= 3'd0;
      res_data_q <= 5'd0;
      done_q     <= 1'b0;
      checksum_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      res_sel_q  <= res_sel_d;
      res_data_q <= res_data_d;
      done_q     <= done_d;
      checksum_q <= checksum_d;
    end
  end

  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.ALU_Sel   = sel_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = valid_q;
  assign bus.res_sel   = res_sel_q;
  assign bus.res_data  = res_data_q;
  assign bus.done      = done_q;
  assign bus.checksum  = checksum_q;

endmodule

// File: tb/tb_alu_sweep_seq.sv
// Directed bench for alu_sweep_seq: one DUT with DWELL=4 and one with DWELL=1,
// each driving a behavioural alu_4bit stub (Out = A + Sel, Carry = Sel[2]).
module tb_alu_sweep_seq;

  logic clk;
  logic rst_n;

  alu_sweep_seq_if bus4 ();
  alu_sweep_seq_if bus1 ();

  alu_sweep_seq #(.DWELL(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  alu_sweep_seq #(.DWELL(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  assign bus4.ALU_Out   = bus4.A + {1'b0, bus4.ALU_Sel};
  assign bus4.Carry_Out = bus4.ALU_Sel[2];
  assign bus1.ALU_Out   = bus1.A + {1'b0, bus1.ALU_Sel};
  assign bus1.Carry_Out = bus1.ALU_Sel[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit use1   = 1'b0;

  logic       m_valid, m_done, m_busy;
  logic [2:0] m_sel, m_alusel;
  logic [4:0] m_data;
  logic [7:0] m_sum;
  logic [3:0] m_a, m_b;

  always_comb begin
    if (use1) begin
      m_valid = bus1.res_valid; m_done = bus1.done; m_busy = bus1.busy;
      m_sel = bus1.res_sel; m_alusel = bus1.ALU_Sel; m_data = bus1.res_data;
      m_sum = bus1.checksum; m_a = bus1.A; m_b = bus1.B;
    end else begin
      m_valid = bus4.res_valid; m_done = bus4.done; m_busy = bus4.busy;
      m_sel = bus4.res_sel; m_alusel = bus4.ALU_Sel; m_data = bus4.res_data;
      m_sum = bus4.checksum; m_a = bus4.A; m_b = bus4.B;
    end
  end

  typedef struct {
    bit               use1;
    logic [3:0]       a;
    logic [3:0]       b;
    logic [7:0][4:0]  data;
    logic [7:0]       sum;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic ab, input logic [3:0] a, input logic [3:0] b);
    if (use1) begin
      bus1.start = s; bus1.abort = ab; bus1.A_in = a; bus1.B_in = b;
    end else begin
      bus4.start = s; bus4.abort = ab; bus4.A_in = a; bus4.B_in = b;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " A"}, 32'(m_a), 0);
    check({tag, " B"}, 32'(m_b), 0);
    check({tag, " ALU_Sel"}, 32'(m_alusel), 0);
    check({tag, " busy"}, 32'(m_busy), 0);
    check({tag, " res_valid"}, 32'(m_valid), 0);
    check({tag, " res_sel"}, 32'(m_sel), 0);
    check({tag, " res_data"}, 32'(m_data), 0);
    check({tag, " done"}, 32'(m_done), 0);
    check({tag, " checksum"}, 32'(m_sum), 0);
  endtask

  // Full sweep from IDLE; optionally re-pulses start at cycle 5 and in the DONE cycle.
  task automatic run_sweep(input vec_t v, input bit repulse, input string tag);
    int dw;
    int n;
    int ndone;
    use1  = v.use1;
    dw    = v.use1 ? 1 : 4;
    n     = 0;
    ndone = 0;
    drive(1'b1, 1'b0, v.a, v.b);
    tick();
    drive(1'b0, 1'b0, v.a, v.b);
    check({tag, " busy@accept"}, 32'(m_busy), 1);
    check({tag, " A latched"}, 32'(m_a), 32'(v.a));
    check({tag, " B latched"}, 32'(m_b), 32'(v.b));
    check({tag, " ALU_Sel@accept"}, 32'(m_alusel), 0);
    check({tag, " checksum cleared"}, 32'(m_sum), 0);
    for (int k = 1; k <= 8 * dw + 1; k++) begin
      tick();
      if (m_valid) begin
        check({tag, " strobe cycle"}, 32'(k), 32'((n + 1) * dw));
        if (n < 8) begin
          check({tag, " res_sel"}, 32'(m_sel), 32'(n));
          check({tag, " res_data"}, 32'(m_data), 32'(v.data[n]));
        end
        n++;
      end
      if (m_done) begin
        check({tag, " done cycle"}, 32'(k), 32'(8 * dw));
        ndone++;
      end
      drive(repulse && (k == 5 || m_done), 1'b0, v.a, v.b);
    end
    drive(1'b0, 1'b0, v.a, v.b);
    check({tag, " strobe count"}, 32'(n), 8);
    check({tag, " done count"}, 32'(ndone), 1);
    check({tag, " busy after"}, 32'(m_busy), 0);
    check({tag, " checksum"}, 32'(m_sum), 32'(v.sum));
    check({tag, " res_data hold"}, 32'(m_data), 32'(v.data[7]));
    check({tag, " res_sel hold"}, 32'(m_sel), 7);
  endtask

  vec_t vecs[4];
  vec_t v_a3;
  int   nv;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 4'd3, 4'd1,
                {5'd26, 5'd25, 5'd24, 5'd23, 5'd6, 5'd5, 5'd4, 5'd3}, 8'h74};
    vecs[1] = '{1'b0, 4'd9, 4'd5,
                {5'd16, 5'd31, 5'd30, 5'd29, 5'd12, 5'd11, 5'd10, 5'd9}, 8'h94};
    vecs[2] = '{1'b1, 4'd15, 4'd2,
                {5'd22, 5'd21, 5'd20, 5'd19, 5'd2, 5'd1, 5'd0, 5'd15}, 8'h64};
    vecs[3] = '{1'b1, 4'd0, 4'd7,
                {5'd23, 5'd22, 5'd21, 5'd20, 5'd3, 5'd2, 5'd1, 5'd0}, 8'h5C};
    v_a3 = vecs[0];

    bus4.start = 0; bus4.abort = 0; bus4.A_in = 0; bus4.B_in = 0;
    bus1.start = 0; bus1.abort = 0; bus1.A_in = 0; bus1.B_in = 0;
    rst_n = 1'b0;
    #22 rst_n = 1'b1;
    tick();
    use1 = 1'b0; check_outputs_zero("reset dwell4");
    use1 = 1'b1; check_outputs_zero("reset dwell1");

    foreach (vecs[i]) begin
      run_sweep(vecs[i], 1'b0, $sformatf("vec%0d", i));
      tick();
    end

    // start re-pulsed mid-sweep and in the DONE cycle
    run_sweep(v_a3, 1'b1, "repulse");

    // abort after the third strobe
    use1 = 1'b0;
    drive(1'b1, 1'b0, 4'd3, 4'd1);
    tick();
    drive(1'b0, 1'b0, 4'd3, 4'd1);
    nv = 0;
    for (int k = 1; k <= 20 && nv < 3; k++) begin
      tick();
      if (m_valid) nv++;
    end
    check("abort third strobe seen", 32'(nv), 3);
    drive(1'b0, 1'b1, 4'd3, 4'd1);
    tick();
    drive(1'b0, 1'b0, 4'd3, 4'd1);
    check("abort busy", 32'(m_busy), 0);
    check("abort res_valid", 32'(m_valid), 0);
    check("abort checksum", 32'(m_sum), 12);
    check("abort A hold", 32'(m_a), 3);
    check("abort ALU_Sel hold", 32'(m_alusel), 3);
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (m_valid || m_done || m_busy) nv++;
    end
    check("abort quiet", 32'(nv), 0);
    run_sweep(v_a3, 1'b0, "after abort");
    tick();

    // asynchronous reset mid-DRIVE
    use1 = 1'b0;
    drive(1'b1, 1'b0, 4'd5, 4'd2);
    tick();
    drive(1'b0, 1'b0, 4'd5, 4'd2);
    for (int k = 0; k < 10; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("async reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (m_valid || m_done || m_busy) nv++;
    end
    check("post reset idle", 32'(nv), 0);
    run_sweep(v_a3, 1'b0, "after reset");
    tick();

    // start and abort together in IDLE
    use1 = 1'b0;
    drive(1'b1, 1'b1, 4'd3, 4'd1);
    tick();
    drive(1'b0, 1'b0, 4'd3, 4'd1);
    check("start+abort busy", 32'(m_busy), 0);
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (m_valid || m_done || m_busy) nv++;
    end
    check("start+abort quiet", 32'(nv), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
